fib_engine: RTL and testbench
=============================

// Module: fib_engine
// PURPOSE
//  Parametrised iterative engine for two-term additive recurrences: from (a,b) it applies
//  (a,b) <- (b, a (+) b) exactly n times and returns the final a. Fixed widths become
//  parameters; recursion becomes a counted loop. Adds saturating and modular add modes, a
//  sticky overflow flag and a busy indication. Top-level compute core driven by the host's
//  r_enable / w_enable handshake.
// PARAMETERS
//  WIDTH    32  data width of a, b, m, result
//  N_WIDTH  6   width of iteration count init_n
// PORTS
//  clk        in   1        sole clock; all state updates on posedge clk
//  rst        in   1        reset, synchronous, active-high
//  r_enable   in   1        start strobe; samples mode/init_* on the same edge
//  mode       in   2        0 wrap, 1 saturate, 2 modulo init_m, 3 reserved (= wrap)
//  init_n     in   N_WIDTH  iteration count n
//  init_a     in   WIDTH    seed a (term 0)
//  init_b     in   WIDTH    seed b (term 1)
//  init_m     in   WIDTH    modulus, used in mode 2 only
//  busy       out  1        high while iterating
//  w_enable   out  1        result valid, held until next start or reset
//  result     out  WIDTH    final a
//  overflow   out  1        sticky: some add carried out of WIDTH (modes 0/1)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, w_enable=0, result=0, overflow=0, internal regs 0.
//    rst wins over r_enable on the same edge; rst mid-run aborts with no w_enable.
//  - States: IDLE -> RUN on r_enable; RUN -> RUN while cnt!=0; RUN -> DONE when cnt==0;
//    DONE holds until r_enable (-> RUN) or rst (-> IDLE).
//  - Start edge: a<=init_a, b<=init_b, cnt<=init_n, mode/m latched, overflow<=0,
//    w_enable<=0, busy<=1. r_enable is honoured in ANY state: mid-run it restarts cleanly.
//  - RUN edge, cnt!=0: a<=b, b<=f(a,b), cnt<=cnt-1. One iteration per cycle.
//  - RUN edge, cnt==0: result<=a, w_enable<=1, busy<=0, state DONE.
//  - Latency: w_enable high n+1 edges after the start edge (n=0 -> 1 edge, result=init_a).
//  - f(a,b), s = a+b computed at WIDTH+1:
//     wrap:     s[WIDTH-1:0]; overflow |= s[WIDTH]
//     saturate: s[WIDTH] ? all-ones : s; overflow |= s[WIDTH]; saturated term persists
//     modulo:   s>=m ? s-m : s. Requires a,b<m (caller contract); m==0 behaves as wrap.
//  - Overflow counts only additions actually applied (cnt!=0 edges).
//  - Max n = 2^N_WIDTH-1; cnt never wraps (compare to 0 before decrement).
//  - result/overflow stay stable in DONE; inputs other than rst/r_enable ignored after start.
// STRUCTURE
//  - Shared package fib_pkg: mode_e {MODE_WRAP, MODE_SAT, MODE_MOD, MODE_RSVD},
//    state_e {S_IDLE, S_RUN, S_DONE}.
//  - Sub-module fib_step_alu: combinational (a,b,m,mode) -> (next, carry); holds all
//    width/mode arithmetic so the FSM only sequences.
// TESTING
//  - WIDTH=32, mode 0, n=10, a=0, b=1 -> w_enable 11 edges after start, result=55, ovf=0.
//  - n=0, a=7, b=9 -> w_enable after 1 edge, result=7, busy low with it.
//  - WIDTH=8, n=14, a=0, b=1: mode 0 -> result=121, ovf=1; mode 1 -> result=255, ovf=1.
//  - mode 2, m=7, n=10, a=0, b=1 -> result=6 (55 mod 7), ovf=0; m=0 -> behaves as mode 0.
//  - r_enable at RUN cycle 4 with n=5, a=2, b=3 -> first run discarded, result=21 after
//    6 edges from the restart; w_enable never pulses for the aborted run.
//  - rst asserted with r_enable, and rst mid-run -> IDLE, all outputs 0, no w_enable.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types for the additive-recurrence engine: add modes and sequencer states.
package fib_pkg;

  localparam int unsigned FIB_WIDTH_DEF   = 32;
  localparam int unsigned FIB_N_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_MOD  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fib_step_alu.sv
// One recurrence step: combines a and b under the selected add mode and reports
// whether the raw sum carried out of WIDTH.
module fib_step_alu
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    next  = sum[WIDTH-1:0];
    carry = sum[WIDTH];
    case (mode)
      MODE_SAT: begin
        if (sum[WIDTH]) next = '1;
      end
      MODE_MOD: begin
        // a zero modulus falls back to plain wrapping arithmetic
        if (m != '0) begin
          carry = 1'b0;
          if (sum >= {1'b0, m}) next = WIDTH'(sum - {1'b0, m});
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fib_engine.sv
// Iterative two-term recurrence engine: (a,b) <- (b, a+b) n times, result is the final a.
module fib_engine
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH   = FIB_WIDTH_DEF,
  parameter int unsigned N_WIDTH = FIB_N_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r_enable,
  input  logic [1:0]         mode,
  input  logic [N_WIDTH-1:0] init_n,
  input  logic [WIDTH-1:0]   init_a,
  input  logic [WIDTH-1:0]   init_b,
  input  logic [WIDTH-1:0]   init_m,
  output logic               busy,
  output logic               w_enable,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  state_e             state;
  mode_e              mode_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   m_q;
  logic [N_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]   step_next;
  logic               step_carry;

  fib_step_alu #(.WIDTH(WIDTH)) u_step (
    .a     (a_q),
    .b     (b_q),
    .m     (m_q),
    .mode  (mode_q),
    .next  (step_next),
    .carry (step_carry)
  );

  // Sequencer: a start strobe restarts from any state; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= MODE_WRAP;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      w_enable <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (r_enable) begin
      state    <= S_RUN;
      mode_q   <= mode_e'(mode);
      a_q      <= init_a;
      b_q      <= init_b;
      m_q      <= init_m;
      cnt      <= init_n;
      busy     <= 1'b1;
      w_enable <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (cnt != '0) begin
            a_q <= b_q;
            b_q <= step_next;
            cnt <= cnt - N_WIDTH'(1);
            if (step_carry) overflow <= 1'b1;
          end else begin
            result   <= a_q;
            w_enable <= 1'b1;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// Scoreboard bench for fib_engine: one 32-bit and one 8-bit instance share stimulus.
module tb_fib_engine;
  import fib_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
    bit          w8;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en32, r_en8;
  logic [1:0]  mode;
  logic [5:0]  init_n;
  logic [31:0] init_a, init_b, init_m;
  logic        busy32, we32, ovf32;
  logic [31:0] res32;
  logic        busy8, we8, ovf8;
  logic [7:0]  res8;
  logic [7:0]  a8, b8, m8;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  assign a8 = init_a[7:0];
  assign b8 = init_b[7:0];
  assign m8 = init_m[7:0];

  fib_engine #(.WIDTH(32), .N_WIDTH(6)) dut32 (
    .clk(clk), .rst(rst), .r_enable(r_en32), .mode(mode), .init_n(init_n),
    .init_a(init_a), .init_b(init_b), .init_m(init_m),
    .busy(busy32), .w_enable(we32), .result(res32), .overflow(ovf32)
  );

  fib_engine #(.WIDTH(8), .N_WIDTH(6)) dut8 (
    .clk(clk), .rst(rst), .r_enable(r_en8), .mode(mode), .init_n(init_n),
    .init_a(a8), .init_b(b8), .init_m(m8),
    .busy(busy8), .w_enable(we8), .result(res8), .overflow(ovf8)
  );

  function automatic logic [31:0] cur_res(input bit w8);
    return w8 ? {24'd0, res8} : res32;
  endfunction
  function automatic logic cur_we(input bit w8);
    return w8 ? we8 : we32;
  endfunction
  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction
  function automatic logic cur_ovf(input bit w8);
    return w8 ? ovf8 : ovf32;
  endfunction

  // Reference recurrence evaluated with wide arithmetic and explicit masking.
  function automatic void model(input int w, input logic [1:0] md, input int n,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] m0, output logic [31:0] r,
                                output logic o);
    longint unsigned mask, x, y, s, nx, mm;
    mask = (64'd1 << w) - 64'd1;
    x = {32'd0, a0} & mask;
    y = {32'd0, b0} & mask;
    mm = {32'd0, m0} & mask;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = x + y;
      if (md == 2'd2 && mm != 0) begin
        nx = (s >= mm) ? s - mm : s;
      end else if (s > mask) begin
        o = 1'b1;
        nx = (md == 2'd1) ? mask : (s & mask);
      end else begin
        nx = s;
      end
      x = y;
      y = nx;
    end
    r = x[31:0];
  endfunction

  task automatic launch(input bit w8, input logic [1:0] md, input int n,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                        input bit push, input logic [31:0] er, input logic eo,
                        input string nm);
    @(negedge clk);
    mode = md; init_n = 6'(n); init_a = a; init_b = b; init_m = m;
    if (w8) r_en8 = 1'b1; else r_en32 = 1'b1;
    @(posedge clk);
    #1;
    r_en8 = 1'b0; r_en32 = 1'b0;
    mode = 2'(3 - md); init_a = ~a; init_b = ~b; init_n = ~init_n;
    if (push) sb.push_back('{er, eo, n + 1, w8, nm});
    vectors++;
    if (cur_busy(w8) !== 1'b1) begin
      miscompares++;
      $display("FAIL %s start busy: got %b want 1", nm, cur_busy(w8));
    end
    vectors++;
    if (cur_we(w8) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start w_enable: got %b want 0", nm, cur_we(w8));
    end
  endtask

  // Pop the oldest expectation and wait (bounded) for the matching w_enable.
  task automatic collect();
    exp_t e;
    int   k;
    bit   got;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL collect: scoreboard empty, got 0 entries want >=1");
      return;
    end
    e = sb.pop_front();
    k = 1; got = 0;
    while (!got && k <= e.lat + 8) begin
      @(posedge clk);
      #1;
      if (cur_we(e.w8) === 1'b1) got = 1; else k++;
    end
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout: no w_enable within %0d edges, want %0d", e.name, k - 1, e.lat);
      return;
    end
    vectors++;
    if (k != e.lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", e.name, k, e.lat);
    end
    vectors++;
    if (cur_res(e.w8) !== e.res) begin
      miscompares++;
      $display("FAIL %s result: got %0d want %0d", e.name, cur_res(e.w8), e.res);
    end
    vectors++;
    if (cur_ovf(e.w8) !== e.ovf) begin
      miscompares++;
      $display("FAIL %s overflow: got %b want %b", e.name, cur_ovf(e.w8), e.ovf);
    end
    vectors++;
    if (cur_busy(e.w8) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done busy: got %b want 0", e.name, cur_busy(e.w8));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; r_en32 = 1'b0; r_en8 = 1'b0;
    mode = 2'd0; init_n = '0; init_a = '0; init_b = '0; init_m = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy32, we32, ovf32, res32} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset32: got b=%b w=%b o=%b r=%0d want all 0", busy32, we32, ovf32, res32);
    end
    vectors++;
    if ({busy8, we8, ovf8, res8} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8: got b=%b w=%b o=%b r=%0d want all 0", busy8, we8, ovf8, res8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap32();
    launch(0, 2'd0, 10, 32'd0, 32'd1, 32'd0, 1, 32'd55, 1'b0, "wrap32_n10");
    collect();
  endtask

  task automatic test_n_zero();
    launch(0, 2'd0, 0, 32'd7, 32'd9, 32'd0, 1, 32'd7, 1'b0, "n0");
    collect();
  endtask

  task automatic test_width8();
    launch(1, 2'd0, 14, 32'd0, 32'd1, 32'd0, 1, 32'd121, 1'b1, "w8_wrap");
    collect();
    launch(1, 2'd1, 14, 32'd0, 32'd1, 32'd0, 1, 32'd255, 1'b1, "w8_sat");
    collect();
    launch(1, 2'd3, 14, 32'd0, 32'd1, 32'd0, 1, 32'd121, 1'b1, "w8_rsvd");
    collect();
  endtask

  task automatic test_modulo();
    launch(0, 2'd2, 10, 32'd0, 32'd1, 32'd7, 1, 32'd6, 1'b0, "mod7");
    collect();
    launch(0, 2'd2, 10, 32'd0, 32'd1, 32'd0, 1, 32'd55, 1'b0, "mod0");
    collect();
    launch(1, 2'd2, 14, 32'd0, 32'd1, 32'd0, 1, 32'd121, 1'b1, "w8_mod0");
    collect();
  endtask

  task automatic test_back_to_back();
    launch(0, 2'd0, 3, 32'd1, 32'd1, 32'd0, 1, 32'd3, 1'b0, "b2b_first");
    collect();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (we32 !== 1'b1 || res32 !== 32'd3) begin
      miscompares++;
      $display("FAIL hold_done: got w=%b r=%0d want w=1 r=3", we32, res32);
    end
    launch(0, 2'd0, 4, 32'd5, 32'd8, 32'd0, 1, 32'd34, 1'b0, "b2b_second");
    collect();
  endtask

  task automatic test_restart();
    bit pulsed = 0;
    launch(0, 2'd0, 10, 32'd0, 32'd1, 32'd0, 0, 32'd0, 1'b0, "restart_first");
    repeat (3) begin
      @(posedge clk);
      #1;
      if (we32 === 1'b1) pulsed = 1;
    end
    launch(0, 2'd0, 5, 32'd2, 32'd3, 32'd0, 1, 32'd21, 1'b0, "restart_second");
    collect();
    vectors++;
    if (pulsed) begin
      miscompares++;
      $display("FAIL restart_abort: got w_enable pulse want none");
    end
  endtask

  task automatic test_rst_cases();
    bit pulsed = 0;
    @(negedge clk);
    rst = 1'b1; r_en32 = 1'b1;
    mode = 2'd0; init_n = 6'd2; init_a = 32'd4; init_b = 32'd4;
    @(posedge clk);
    #1;
    rst = 1'b0; r_en32 = 1'b0;
    vectors++;
    if ({busy32, we32, ovf32, res32} !== 35'd0) begin
      miscompares++;
      $display("FAIL rst_with_start: got b=%b w=%b o=%b r=%0d want all 0", busy32, we32, ovf32, res32);
    end
    launch(0, 2'd1, 20, 32'hF000_0000, 32'hF000_0000, 32'd0, 0, 32'd0, 1'b0, "rst_mid");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({busy32, we32, ovf32, res32} !== 35'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got b=%b w=%b o=%b r=%0d want all 0", busy32, we32, ovf32, res32);
    end
    repeat (25) begin
      @(posedge clk);
      #1;
      if (we32 === 1'b1 || busy32 === 1'b1) pulsed = 1;
    end
    vectors++;
    if (pulsed) begin
      miscompares++;
      $display("FAIL rst_mid_idle: got activity after reset want none");
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, m, r;
    logic [1:0]  md;
    logic        o;
    int          n;
    bit          w8;
    for (int i = 0; i < 12; i++) begin
      w8 = (i % 2) == 0;
      md = 2'($urandom_range(0, 3));
      n  = $urandom_range(0, 63);
      if (md == 2'd2) begin
        m = w8 ? 32'($urandom_range(1, 255)) : $urandom() | 32'd1;
        a = 32'($urandom() % m);
        b = 32'($urandom() % m);
      end else begin
        m = $urandom();
        a = w8 ? 32'($urandom_range(0, 255)) : $urandom();
        b = w8 ? 32'($urandom_range(0, 255)) : $urandom();
      end
      model(w8 ? 8 : 32, md, n, a, b, m, r, o);
      launch(w8, md, n, a, b, m, 1, r, o, $sformatf("rand%0d", i));
      collect();
    end
  endtask

  initial begin
    test_reset();
    test_wrap32();
    test_n_zero();
    test_width8();
    test_modulo();
    test_back_to_back();
    test_restart();
    test_rst_cases();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
